// File: rtl/alu_pkg.sv
// Shared encodings for the ID/EX issue stage feeding ALU_32: op codes, opcode/funct
// constants, decode and pipeline-register payload types.
package alu_pkg;

  localparam int unsigned W  = 32;
  localparam int unsigned RA = 5;

  typedef enum logic [2:0] {
    ALU_OR   = 3'd0,
    ALU_AND  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_ADD  = 3'd3,
    ALU_NOR  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_SUB  = 3'd7
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    alu_op_e m;
    logic    b_imm;     // b from immediate instead of rt_data
    logic    sext;
    logic    wr_rd;     // destination is rd (R-type) rather than rt
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    illegal;
    logic    uses_rt;
  } dec_t;

  typedef struct packed {
    logic            valid;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    store_data;
    alu_op_e         m;
    logic [RA-1:0]   wr_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;
  } ex_t;

  function automatic logic [W-1:0] ext_imm(input logic [15:0] imm, input logic sext);
    return sext ? {{(W-16){imm[15]}}, imm} : {{(W-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// ID-side request and EX-side issued word of the ID/EX stage; master is the stage itself.
interface id_ex_alu_issue_if;

  logic                      id_valid;
  logic                      id_ready;
  logic [31:0]               id_instr;
  logic [alu_pkg::W-1:0]     rs_data;
  logic [alu_pkg::W-1:0]     rt_data;
  logic                      flush;
  logic                      ex_ready;
  logic                      ex_valid;
  logic [alu_pkg::W-1:0]     ex_a;
  logic [alu_pkg::W-1:0]     ex_b;
  logic [2:0]                ex_m;
  logic [alu_pkg::RA-1:0]    ex_wr_reg;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [alu_pkg::W-1:0]     ex_store_data;
  logic                      ex_branch;
  logic                      ex_illegal;

  modport master (
    input  id_valid, id_instr, rs_data, rt_data, flush, ex_ready,
    output id_ready, ex_valid, ex_a, ex_b, ex_m, ex_wr_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, ex_branch, ex_illegal
  );

  modport slave (
    output id_valid, id_instr, rs_data, rt_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b, ex_m, ex_wr_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, ex_branch, ex_illegal
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS-subset decode: opcode/funct -> ALU op, operand selects, control bits.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o   = '0;
    dec_o.m = ALU_OR;
    unique case (op_i)
      OP_RTYPE: begin
        dec_o.wr_rd     = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.uses_rt   = 1'b1;
        unique case (funct_i)
          FN_ADD:  dec_o.m = ALU_ADD;
          FN_SUB:  dec_o.m = ALU_SUB;
          FN_AND:  dec_o.m = ALU_AND;
          FN_OR:   dec_o.m = ALU_OR;
          FN_XOR:  dec_o.m = ALU_XOR;
          FN_NOR:  dec_o.m = ALU_NOR;
          FN_SLT:  dec_o.m = ALU_SLT;
          default: begin
            dec_o         = '0;
            dec_o.m       = ALU_OR;
            dec_o.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_LW: begin
        dec_o.m         = (op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        dec_o.b_imm     = 1'b1;
        dec_o.sext      = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.mem_read  = (op_i == OP_LW);
      end
      OP_SW: begin
        dec_o.m         = ALU_ADD;
        dec_o.b_imm     = 1'b1;
        dec_o.sext      = 1'b1;
        dec_o.mem_write = 1'b1;
        dec_o.uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        // compare via SUB against rt_data; zero test lives downstream
        dec_o.m       = ALU_SUB;
        dec_o.sext    = 1'b1;
        dec_o.branch  = 1'b1;
        dec_o.uses_rt = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_o.m         = (op_i == OP_ANDI) ? ALU_AND :
                          (op_i == OP_ORI)  ? ALU_OR  : ALU_XOR;
        dec_o.b_imm     = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for ALU_32: decode, operand build, load-use bubble and
// valid/ready flow control with flush.
module id_ex_alu_issue
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  id_ex_alu_issue_if.master    bus
);

  dec_t          dec;
  ex_t           ex_q, ex_d;
  logic [RA-1:0] rs_a, rt_a, rd_a, dst;
  logic          hazard_c, id_ready_c;

  assign rs_a = bus.id_instr[25:21];
  assign rt_a = bus.id_instr[20:16];
  assign rd_a = bus.id_instr[15:11];

  alu_ctrl_decode u_decode (
    .op_i    (bus.id_instr[31:26]),
    .funct_i (bus.id_instr[5:0]),
    .dec_o   (dec)
  );

  assign dst = dec.wr_rd ? rd_a : rt_a;

  // Load in EX whose result the ID word needs cannot be forwarded in time
  assign hazard_c = ex_q.valid & ex_q.mem_read & (ex_q.wr_reg != '0) &
                    ((ex_q.wr_reg == rs_a) | (dec.uses_rt & (ex_q.wr_reg == rt_a)));

  assign id_ready_c   = ~hazard_c & (bus.ex_ready | ~ex_q.valid);
  assign bus.id_ready = id_ready_c;

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d.valid = 1'b0;
    end else if (hazard_c & bus.ex_ready) begin
      ex_d.valid = 1'b0;
    end else if (bus.id_valid & id_ready_c) begin
      ex_d.valid      = 1'b1;
      ex_d.a          = bus.rs_data;
      ex_d.b          = dec.b_imm ? ext_imm(bus.id_instr[15:0], dec.sext) : bus.rt_data;
      ex_d.store_data = bus.rt_data;
      ex_d.m          = dec.m;
      ex_d.wr_reg     = dst;
      ex_d.reg_write  = dec.reg_write & (dst != '0);
      ex_d.mem_read   = dec.mem_read;
      ex_d.mem_write  = dec.mem_write;
      ex_d.branch     = dec.branch;
      ex_d.illegal    = dec.illegal;
    end else if (bus.ex_ready & ~bus.id_valid) begin
      ex_d.valid = 1'b0;
    end
    // side-effecting controls must never be live on a bubble
    if (!ex_d.valid) begin
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      ex_q.m <= ALU_OR;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_a          = ex_q.a;
  assign bus.ex_b          = ex_q.b;
  assign bus.ex_m          = ex_q.m;
  assign bus.ex_wr_reg     = ex_q.wr_reg;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_store_data = ex_q.store_data;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: decode, immediates, load-use bubble, stall, flush, reset.
module tb_id_ex_alu_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue_if bus ();

  id_ex_alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.id_valid = v;
    bus.id_instr = instr;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", bus.ex_valid); end
    checks++; if (bus.ex_a !== 32'h0) begin failures++; $display("FAIL rst_a got=%h exp=0", bus.ex_a); end
    checks++; if (bus.ex_b !== 32'h0) begin failures++; $display("FAIL rst_b got=%h exp=0", bus.ex_b); end
    checks++; if (bus.ex_m !== 3'd0) begin failures++; $display("FAIL rst_m got=%0d exp=0", bus.ex_m); end
    checks++; if (bus.ex_reg_write !== 1'b0 || bus.ex_illegal !== 1'b0 || bus.ex_mem_read !== 1'b0)
      begin failures++; $display("FAIL rst_ctrl got=%b%b%b exp=000", bus.ex_reg_write, bus.ex_illegal, bus.ex_mem_read); end
    checks++; if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL rst_id_ready got=%0b exp=1", bus.id_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    drive(1'b1, 32'h00221820, 32'd5, 32'd7);
    step();
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", bus.ex_valid); end
    checks++; if (bus.ex_m !== 3'd3) begin failures++; $display("FAIL add_m got=%0d exp=3", bus.ex_m); end
    checks++; if (bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7) begin failures++; $display("FAIL add_ab got=%0d,%0d exp=5,7", bus.ex_a, bus.ex_b); end
    checks++; if (bus.ex_wr_reg !== 5'd3 || bus.ex_reg_write !== 1'b1)
      begin failures++; $display("FAIL add_wr got=%0d/%0b exp=3/1", bus.ex_wr_reg, bus.ex_reg_write); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%0b exp=0", bus.ex_valid); end
  endtask

  task automatic test_imm();
    drive(1'b1, 32'h3404FFFF, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_b !== 32'h0000FFFF || bus.ex_m !== 3'd0)
      begin failures++; $display("FAIL ori got=b%h m%0d exp=b0000ffff m0", bus.ex_b, bus.ex_m); end
    checks++; if (bus.ex_wr_reg !== 5'd4 || bus.ex_reg_write !== 1'b1)
      begin failures++; $display("FAIL ori_wr got=%0d/%0b exp=4/1", bus.ex_wr_reg, bus.ex_reg_write); end
    drive(1'b1, 32'h2004FFFF, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_b !== 32'hFFFFFFFF || bus.ex_m !== 3'd3)
      begin failures++; $display("FAIL addi got=b%h m%0d exp=bffffffff m3", bus.ex_b, bus.ex_m); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h8C220000, 32'h100, 32'h0);
    step();
    checks++; if (bus.ex_mem_read !== 1'b1 || bus.ex_wr_reg !== 5'd2 || bus.ex_reg_write !== 1'b1)
      begin failures++; $display("FAIL lw got=mr%0b wr%0d rw%0b exp=mr1 wr2 rw1", bus.ex_mem_read, bus.ex_wr_reg, bus.ex_reg_write); end
    drive(1'b1, 32'h00422820, 32'd9, 32'd9);
    #1;
    checks++; if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL lu_stall got=%0b exp=0", bus.id_ready); end
    step();
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0)
      begin failures++; $display("FAIL lu_bubble got=v%0b mr%0b exp=v0 mr0", bus.ex_valid, bus.ex_mem_read); end
    checks++; if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL lu_ready got=%0b exp=1", bus.id_ready); end
    step();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_wr_reg !== 5'd5 || bus.ex_a !== 32'd9)
      begin failures++; $display("FAIL lu_issue got=v%0b wr%0d a%0d exp=v1 wr5 a9", bus.ex_valid, bus.ex_wr_reg, bus.ex_a); end
    drive(1'b1, 32'h8C200000, 32'h100, 32'h0);
    step();
    checks++; if (bus.ex_mem_read !== 1'b1 || bus.ex_reg_write !== 1'b0)
      begin failures++; $display("FAIL lw0 got=mr%0b rw%0b exp=mr1 rw0", bus.ex_mem_read, bus.ex_reg_write); end
    drive(1'b1, 32'h00002820, 32'h0, 32'h0);
    #1;
    checks++; if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL lw0_nostall got=%0b exp=1", bus.id_ready); end
    step();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_wr_reg !== 5'd5)
      begin failures++; $display("FAIL lw0_issue got=v%0b wr%0d exp=v1 wr5", bus.ex_valid, bus.ex_wr_reg); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h20060001, 32'h0, 32'h0);
    step();
    bus.ex_ready = 1'b0;
    drive(1'b1, 32'h20070002, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%0b exp=0", i, bus.id_ready); end
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_b !== 32'd1 || bus.ex_wr_reg !== 5'd6)
        begin failures++; $display("FAIL stall_hold[%0d] got=v%0b b%0d wr%0d exp=v1 b1 wr6", i, bus.ex_valid, bus.ex_b, bus.ex_wr_reg); end
      step();
    end
    bus.ex_ready = 1'b1;
    #1;
    checks++; if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%0b exp=1", bus.id_ready); end
    step();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_b !== 32'd2 || bus.ex_wr_reg !== 5'd7)
      begin failures++; $display("FAIL stall_next got=v%0b b%0d wr%0d exp=v1 b2 wr7", bus.ex_valid, bus.ex_b, bus.ex_wr_reg); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL stall_nodup got=%0b exp=0", bus.ex_valid); end
  endtask

  task automatic test_flush_illegal();
    drive(1'b1, 32'h20080003, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL fl_pre got=%0b exp=1", bus.ex_valid); end
    drive(1'b1, 32'h20090004, 32'h0, 32'h0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0)
      begin failures++; $display("FAIL flush got=v%0b rw%0b exp=v0 rw0", bus.ex_valid, bus.ex_reg_write); end
    checks++; if (bus.ex_b !== 32'd3) begin failures++; $display("FAIL flush_nocap got=b%0d exp=b3", bus.ex_b); end
    drive(1'b1, 32'hFC000000, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_illegal !== 1'b1 || bus.ex_valid !== 1'b1)
      begin failures++; $display("FAIL illegal_op got=il%0b v%0b exp=il1 v1", bus.ex_illegal, bus.ex_valid); end
    checks++; if (bus.ex_reg_write !== 1'b0 || bus.ex_m !== 3'd0 || bus.ex_mem_write !== 1'b0)
      begin failures++; $display("FAIL illegal_ctrl got=rw%0b m%0d mw%0b exp=rw0 m0 mw0", bus.ex_reg_write, bus.ex_m, bus.ex_mem_write); end
    drive(1'b1, 32'h00000000, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_illegal !== 1'b1 || bus.ex_reg_write !== 1'b0)
      begin failures++; $display("FAIL illegal_fn got=il%0b rw%0b exp=il1 rw0", bus.ex_illegal, bus.ex_reg_write); end
    drive(1'b1, 32'hAC230010, 32'h40, 32'hCAFE);
    step();
    checks++; if (bus.ex_mem_write !== 1'b1 || bus.ex_store_data !== 32'hCAFE || bus.ex_b !== 32'h10 || bus.ex_reg_write !== 1'b0)
      begin failures++; $display("FAIL sw got=mw%0b sd%h b%h rw%0b exp=mw1 sd0000cafe b00000010 rw0", bus.ex_mem_write, bus.ex_store_data, bus.ex_b, bus.ex_reg_write); end
    drive(1'b1, 32'h1022FFFE, 32'd4, 32'd4);
    step();
    checks++; if (bus.ex_branch !== 1'b1 || bus.ex_m !== 3'd7 || bus.ex_b !== 32'd4)
      begin failures++; $display("FAIL beq got=br%0b m%0d b%0d exp=br1 m7 b4", bus.ex_branch, bus.ex_m, bus.ex_b); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    checks++; if (bus.ex_illegal !== 1'b0 || bus.ex_valid !== 1'b0)
      begin failures++; $display("FAIL idle_clear got=il%0b v%0b exp=il0 v0", bus.ex_illegal, bus.ex_valid); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h200A0005, 32'h0, 32'h0);
    step();
    bus.ex_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'd5, 32'd7);
    step();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_b !== 32'd5)
      begin failures++; $display("FAIL rms_pre got=v%0b b%0d exp=v1 b5", bus.ex_valid, bus.ex_b); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_a !== 32'h0 || bus.ex_b !== 32'h0 || bus.ex_wr_reg !== 5'd0 || bus.ex_reg_write !== 1'b0)
      begin failures++; $display("FAIL rms_async got=v%0b a%h b%h wr%0d rw%0b exp=all0", bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_wr_reg, bus.ex_reg_write); end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.ex_ready = 1'b1;
    step();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_m !== 3'd3 || bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7)
      begin failures++; $display("FAIL rms_first got=v%0b m%0d a%0d b%0d exp=v1 m3 a5 b7", bus.ex_valid, bus.ex_m, bus.ex_a, bus.ex_b); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_load_use();
    test_stall();
    test_flush_illegal();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
